branch_cond_pipe: RTL and testbench

- Pipelined branch-condition evaluator for the MIPS datapath. It generalises the single-word combinational zero detector into a registered two-stage unit.
- Chunked zero reduction with a parametrised bus and chunk size.
- Eight condition modes (EQ/NE/sign/zero compares).
- Stall/flush pipeline control and a saturating taken-branch counter for performance monitoring.

---
 rtl/branch_cond_if.sv | 22 ++
 rtl/branch_cond_pipe.sv | 124 ++++++++++++
 tb/tb_branch_cond_pipe.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_cond_if.sv
// Operand/result bundle for branch_cond_pipe; signal directions are named from the evaluator's side.
interface branch_cond_if #(
  parameter int unsigned BUS_SIZE = 32
);
  logic                i_valid;
  logic [2:0]          i_mode;
  logic [BUS_SIZE-1:0] i_a;
  logic [BUS_SIZE-1:0] i_b;
  logic                o_valid;
  logic                o_taken;
  logic                o_is_zero;

  modport master (
    output i_valid, i_mode, i_a, i_b,
    input  o_valid, o_taken, o_is_zero
  );

  modport slave (
    input  i_valid, i_mode, i_a, i_b,
    output o_valid, o_taken, o_is_zero
  );
endinterface

// File: rtl/branch_cond_pipe.sv
// Two-stage branch-condition evaluator: stage 1 registers per-chunk zero flags, stage 2 reduces
// them, applies the condition mode and drives a saturating taken-branch counter.
module branch_cond_pipe #(
  parameter int unsigned BUS_SIZE    = 32,
  parameter int unsigned CHUNK_SIZE  = 8,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_stall,
  input  logic                   i_flush,
  input  logic                   i_count_clr,
  branch_cond_if.slave           b_if,
  output logic [COUNT_WIDTH-1:0] o_taken_count
);

  localparam int unsigned NCH = BUS_SIZE / CHUNK_SIZE;
  localparam logic [COUNT_WIDTH-1:0] CountOne = COUNT_WIDTH'(1);

  if ((CHUNK_SIZE == 0) || ((BUS_SIZE % CHUNK_SIZE) != 0)) begin : g_bad_chunk
    $error("BUS_SIZE must be a non-zero integer multiple of CHUNK_SIZE");
  end

  typedef enum logic [2:0] {
    ModeEq      = 3'd0,
    ModeNe      = 3'd1,
    ModeLtz     = 3'd2,
    ModeGez     = 3'd3,
    ModeLez     = 3'd4,
    ModeGtz     = 3'd5,
    ModeZero    = 3'd6,
    ModeNonzero = 3'd7
  } mode_e;

  logic [BUS_SIZE-1:0] w_diff;
  logic [NCH-1:0]      w_za_chunk;
  logic [NCH-1:0]      w_zx_chunk;

  assign w_diff = b_if.i_a ^ b_if.i_b;

  for (genvar g = 0; g < NCH; g++) begin : g_chunk
    assign w_za_chunk[g] = ~|b_if.i_a[g*CHUNK_SIZE +: CHUNK_SIZE];
    assign w_zx_chunk[g] = ~|w_diff[g*CHUNK_SIZE +: CHUNK_SIZE];
  end

  logic                   r_s1_valid;
  logic [NCH-1:0]         r_s1_za;
  logic [NCH-1:0]         r_s1_zx;
  logic                   r_s1_sign;
  mode_e                  r_s1_mode;
  logic                   r_valid;
  logic                   r_taken;
  logic                   r_is_zero;
  logic [COUNT_WIDTH-1:0] r_count;

  logic w_za;
  logic w_zx;
  logic w_cond;
  logic w_count_inc;

  assign w_za = &r_s1_za;
  assign w_zx = &r_s1_zx;

  always_comb begin
    w_cond = 1'b0;
    case (r_s1_mode)
      ModeEq:      w_cond = w_zx;
      ModeNe:      w_cond = ~w_zx;
      ModeLtz:     w_cond = r_s1_sign;
      ModeGez:     w_cond = ~r_s1_sign;
      ModeLez:     w_cond = r_s1_sign | w_za;
      ModeGtz:     w_cond = ~r_s1_sign & ~w_za;
      ModeZero:    w_cond = w_za;
      ModeNonzero: w_cond = ~w_za;
      default:     w_cond = 1'b0;
    endcase
  end

  // Only fresh captures count; held or flushed results are never recounted.
  assign w_count_inc = ~i_flush & ~i_stall & r_s1_valid & w_cond & ~(&r_count);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid <= 1'b0;
      r_s1_za    <= '0;
      r_s1_zx    <= '0;
      r_s1_sign  <= 1'b0;
      r_s1_mode  <= ModeEq;
      r_valid    <= 1'b0;
      r_taken    <= 1'b0;
      r_is_zero  <= 1'b0;
    end else if (i_flush) begin
      r_s1_valid <= 1'b0;
      r_valid    <= 1'b0;
      r_taken    <= 1'b0;
      r_is_zero  <= 1'b0;
    end else if (!i_stall) begin
      r_s1_valid <= b_if.i_valid;
      r_s1_za    <= w_za_chunk;
      r_s1_zx    <= w_zx_chunk;
      r_s1_sign  <= b_if.i_a[BUS_SIZE-1];
      r_s1_mode  <= mode_e'(b_if.i_mode);
      r_valid    <= r_s1_valid;
      r_taken    <= r_s1_valid & w_cond;
      r_is_zero  <= r_s1_valid & w_za;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_count_clr) begin
      r_count <= '0;
    end else if (w_count_inc) begin
      r_count <= r_count + CountOne;
    end
  end

  assign b_if.o_valid   = r_valid;
  assign b_if.o_taken   = r_taken;
  assign b_if.o_is_zero = r_is_zero;
  assign o_taken_count  = r_count;

endmodule

// File: tb/tb_branch_cond_pipe.sv
// Bench for branch_cond_pipe: vector table, directed pipeline-control sequences and random
// stimulus compared every cycle against a result-level reference model.
module tb_branch_cond_pipe;
  localparam int unsigned BW   = 32;
  localparam int unsigned CW   = 4;
  localparam int          CMAX = (1 << CW) - 1;
  localparam int          NVEC = 17;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          stall;
  logic          flush;
  logic          clr;
  logic [CW-1:0] count;

  branch_cond_if #(.BUS_SIZE(BW)) bus ();

  branch_cond_pipe #(
    .BUS_SIZE   (BW),
    .CHUNK_SIZE (8),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_stall      (stall),
    .i_flush      (flush),
    .i_count_clr  (clr),
    .b_if         (bus.slave),
    .o_taken_count(count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    bit v;
    bit t;
    bit z;
  } res_t;

  res_t m_s1;
  res_t m_out;
  int   m_cnt;

  typedef struct {
    logic [2:0]    mode;
    logic [BW-1:0] a;
    logic [BW-1:0] b;
    bit            taken;
    bit            zero;
  } vec_t;

  vec_t tbl[NVEC];

  function automatic bit ref_cond(logic [2:0] m, logic [BW-1:0] a, logic [BW-1:0] b);
    case (m)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd2:    return $signed(a) < 0;
      3'd3:    return $signed(a) >= 0;
      3'd4:    return $signed(a) <= 0;
      3'd5:    return $signed(a) > 0;
      3'd6:    return a == 0;
      default: return a != 0;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1  = '0;
    m_out = '0;
    m_cnt = 0;
  endtask

  // Result-level model: the condition is decided at issue time from plain arithmetic.
  task automatic model_edge();
    bit c;
    c = ref_cond(bus.i_mode, bus.i_a, bus.i_b);
    if (clr) m_cnt = 0;
    else if (!flush && !stall && m_s1.t && m_cnt < CMAX) m_cnt++;
    if (flush) begin
      m_s1  = '0;
      m_out = '0;
    end else if (!stall) begin
      m_out  = m_s1;
      m_s1.v = bus.i_valid;
      m_s1.t = bus.i_valid && c;
      m_s1.z = bus.i_valid && (bus.i_a == '0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("model o_valid", 32'(bus.o_valid), 32'(m_out.v));
    check("model o_taken", 32'(bus.o_taken), 32'(m_out.t));
    check("model o_is_zero", 32'(bus.o_is_zero), 32'(m_out.z));
    check("model count", 32'(count), 32'(m_cnt));
  endtask

  task automatic drive(bit v, logic [2:0] m, logic [BW-1:0] a, logic [BW-1:0] b);
    bus.i_valid = v;
    bus.i_mode  = m;
    bus.i_a     = a;
    bus.i_b     = b;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, '0, '0);
  endtask

  initial begin
    logic [BW-1:0] ra;
    logic [BW-1:0] rb;

    tbl[0]  = '{3'd0, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1};
    tbl[1]  = '{3'd2, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b0};
    tbl[2]  = '{3'd5, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
    tbl[3]  = '{3'd1, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0};
    tbl[4]  = '{3'd4, 32'h0000_0000, 32'h1234_5678, 1'b1, 1'b1};
    tbl[5]  = '{3'd6, 32'h0000_0100, 32'h0000_0000, 1'b0, 1'b0};
    tbl[6]  = '{3'd3, 32'h7fff_ffff, 32'h0000_0000, 1'b1, 1'b0};
    tbl[7]  = '{3'd3, 32'hffff_ffff, 32'h0000_0000, 1'b0, 1'b0};
    tbl[8]  = '{3'd4, 32'hffff_ffff, 32'h0000_0000, 1'b1, 1'b0};
    tbl[9]  = '{3'd5, 32'h0000_0000, 32'hffff_ffff, 1'b0, 1'b1};
    tbl[10] = '{3'd7, 32'h0100_0000, 32'h0000_0000, 1'b1, 1'b0};
    tbl[11] = '{3'd0, 32'h1234_5678, 32'h1234_5679, 1'b0, 1'b0};
    tbl[12] = '{3'd1, 32'hdead_beef, 32'h5ead_beef, 1'b1, 1'b0};
    tbl[13] = '{3'd6, 32'h0000_0000, 32'hffff_ffff, 1'b1, 1'b1};
    tbl[14] = '{3'd2, 32'h7fff_ffff, 32'h0000_0000, 1'b0, 1'b0};
    tbl[15] = '{3'd7, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1};
    tbl[16] = '{3'd0, 32'hab00_0000, 32'hab00_0000, 1'b1, 1'b0};

    reset_n = 1'b0;
    stall   = 1'b0;
    flush   = 1'b0;
    clr     = 1'b0;
    idle();
    model_reset();
    #2;
    check("reset o_valid", 32'(bus.o_valid), 32'd0);
    check("reset o_taken", 32'(bus.o_taken), 32'd0);
    check("reset o_is_zero", 32'(bus.o_is_zero), 32'd0);
    check("reset count", 32'(count), 32'd0);
    @(posedge clk);
    #3 reset_n = 1'b1;

    // Single EQ of zeros: two-edge latency, one-cycle result.
    drive(1'b1, 3'd0, '0, '0);
    tick();
    idle();
    tick();
    check("t1 o_valid", 32'(bus.o_valid), 32'd1);
    check("t1 o_taken", 32'(bus.o_taken), 32'd1);
    check("t1 o_is_zero", 32'(bus.o_is_zero), 32'd1);
    tick();
    check("t1 o_valid drop", 32'(bus.o_valid), 32'd0);
    check("t1 o_taken drop", 32'(bus.o_taken), 32'd0);
    check("t1 count", 32'(count), 32'd1);

    // Back-to-back table sweep.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i <= NVEC; i++) begin
      if (i < NVEC) drive(1'b1, tbl[i].mode, tbl[i].a, tbl[i].b);
      else idle();
      tick();
      if (i >= 1) begin
        check($sformatf("vec%0d o_valid", i - 1), 32'(bus.o_valid), 32'd1);
        check($sformatf("vec%0d o_taken", i - 1), 32'(bus.o_taken), 32'(tbl[i-1].taken));
        check($sformatf("vec%0d o_is_zero", i - 1), 32'(bus.o_is_zero), 32'(tbl[i-1].zero));
      end
    end
    check("sweep count", 32'(count), 32'd10);

    // Stall while the op sits in stage 1; stalled inputs must be ignored.
    drive(1'b1, 3'd0, 32'd5, 32'd5);
    tick();
    stall = 1'b1;
    drive(1'b1, 3'd6, '0, '0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall o_valid", 32'(bus.o_valid), 32'd0);
    end
    stall = 1'b0;
    idle();
    tick();
    check("post-stall o_valid", 32'(bus.o_valid), 32'd1);
    check("post-stall o_taken", 32'(bus.o_taken), 32'd1);
    check("post-stall count", 32'(count), 32'd11);
    tick();
    check("post-stall drop", 32'(bus.o_valid), 32'd0);
    check("post-stall count hold", 32'(count), 32'd11);

    // Flush beats stall with two ops in flight.
    drive(1'b1, 3'd0, 32'd7, 32'd7);
    tick();
    drive(1'b1, 3'd0, 32'd9, 32'd9);
    tick();
    check("pre-flush count", 32'(count), 32'd12);
    stall = 1'b1;
    flush = 1'b1;
    drive(1'b1, 3'd0, 32'd3, 32'd3);
    tick();
    check("flush o_valid", 32'(bus.o_valid), 32'd0);
    stall = 1'b0;
    flush = 1'b0;
    idle();
    for (int i = 0; i < 2; i++) begin
      tick();
      check("post-flush o_valid", 32'(bus.o_valid), 32'd0);
    end
    check("post-flush count", 32'(count), 32'd12);

    // Saturation, then clear colliding with a taken capture.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    drive(1'b1, 3'd0, '0, '0);
    repeat (17) tick();
    idle();
    tick();
    tick();
    check("saturated count", 32'(count), 32'(CMAX));
    drive(1'b1, 3'd6, '0, '0);
    tick();
    idle();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr beats inc", 32'(count), 32'd0);
    check("clr edge o_taken", 32'(bus.o_taken), 32'd1);

    // Asynchronous reset mid-cycle with a live result and count 7.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    drive(1'b1, 3'd7, 32'h10, '0);
    repeat (7) tick();
    idle();
    tick();
    check("pre-reset count", 32'(count), 32'd7);
    check("pre-reset o_valid", 32'(bus.o_valid), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("async o_valid", 32'(bus.o_valid), 32'd0);
    check("async o_taken", 32'(bus.o_taken), 32'd0);
    check("async count", 32'(count), 32'd0);
    model_reset();
    #1 reset_n = 1'b1;
    tick();
    drive(1'b1, 3'd5, 32'd1, '0);
    tick();
    check("post-reset first edge", 32'(bus.o_valid), 32'd0);
    idle();
    tick();
    check("post-reset o_valid", 32'(bus.o_valid), 32'd1);
    check("post-reset o_taken", 32'(bus.o_taken), 32'd1);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 5))
        0:       ra = '0;
        1:       ra = 32'h8000_0000;
        2:       ra = 32'hffff_ffff;
        3:       ra = 32'd1;
        4:       ra = $urandom & ~(32'hff << (8 * $urandom_range(0, 3)));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 2))
        0:       rb = ra;
        1:       rb = ra ^ (32'd1 << $urandom_range(0, 31));
        default: rb = $urandom;
      endcase
      drive($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), ra, rb);
      stall = $urandom_range(0, 99) < 15;
      flush = $urandom_range(0, 99) < 5;
      clr   = $urandom_range(0, 99) < 3;
      tick();
    end
    stall = 1'b0;
    flush = 1'b0;
    clr   = 1'b0;
    idle();
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
